fractal_stream_receiver: RTL and testbench
==========================================

# fractal_stream_receiver

Consumer for the fractal generator's pixel stream. Takes the 8-bit iteration count, frame start, line end and valid signals; that stream has no backpressure. Checks the stream's framing against the configured width and height, maps each iteration count to 24-bit RGB, and buffers the pixels in a FIFO. It then re-emits them as an AXI4-Stream video master (tdata/tuser/tlast/tvalid/tready) toward the VDMA / display path.

## Interface
- FIFO_DEPTH, 1024, FIFO entries (power of two, ≥ 4); each entry is {tuser, tlast, rgb[23:0]}.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- width_in  in  16  active pixels per line; sampled on each accepted frame-start pixel.
- height_in  in  16  lines per frame; sampled with width_in.
- s_data  in  8  iteration count (255 = did not escape).
- s_frame_start  in  1  first pixel of a frame.
- s_line_end  in  1  last pixel of a line.
- s_valid  in  1  pixel present this cycle; the source cannot be stalled.
- m_axis_tdata  out  24  {R[7:0], G[7:0], B[7:0]}.
- m_axis_tuser  out  1  start of frame.
- m_axis_tlast  out  1  end of line.
- m_axis_tvalid  out  1  output entry valid.
- m_axis_tready  in  1  downstream accepts.
- overflow  out  1  sticky: a pixel arrived while the FIFO was full.
- frame_error  out  1  sticky: the framing disagreed with the x/y counters.
- clear_errors  in  1  synchronous clear of both sticky flags.
- frames_done  out  32  count of complete frames accepted, wraps at 2^32.

## Operation
- FSM states: SYNC and ACTIVE. Reset enters SYNC.
- **SYNC**
  - Every pixel is dropped until s_valid && s_frame_start.
  - That pixel is accepted, width/height are latched, x and y are set to 0, and the FSM goes to ACTIVE.
- **ACTIVE**, for every s_valid pixel:
  - **Frame start mid-frame:** s_frame_start with (x,y) ≠ (0,0) sets frame_error. The pixel is accepted as a new frame start: width/height are re-latched and x/y are reset.
  - **Line end mismatch:** s_line_end ≠ (x == width−1) sets frame_error. The pixel is dropped and the FSM goes to SYNC.
  - **Otherwise:** the pixel is accepted.
    - x increments.
    - At x == width−1, x returns to 0 and y increments.
    - At the last pixel (x == width−1, y == height−1), y returns to 0 and frames_done increments.
- **Overflow:** an accepted pixel that finds the FIFO full is dropped, overflow is set, and the FSM goes to SYNC.
  - Full is evaluated at the write edge including a same-cycle pop. If full and popping, the write succeeds.
- **Colour map**, on accepted pixels, registered (stage 1):
  - iter == 255 → 0x000000.
  - Otherwise R = iter, G = {iter[6:0],1'b0}, B = {iter[5:0],2'b00}, all modulo 256.
- **Output:** tuser = accepted-as-frame-start, tlast = s_line_end.
  - The FIFO is first-word-fall-through: m_axis_tvalid = !empty.
  - An entry pops when tvalid && tready.
  - tdata, tuser and tlast stay stable while tvalid && !tready.
- Entries already in the FIFO when an error occurs are still emitted; there is no flush.
- **clear_errors:** clears both flags. If an error event occurs in the same cycle, the flag ends set; the set wins.
- width_in or height_in of 0 is illegal and is not checked. Width 1 means every pixel has line_end.

## Timing
- Reset values:
  - m_axis_tvalid = 0.
  - m_axis_tdata, m_axis_tuser and m_axis_tlast = 0.
  - overflow, frame_error = 0.
  - frames_done = 0.
  - FIFO empty, FSM = SYNC.
- Latency:
  - A pixel sampled at edge N is in the colour register after edge N.
  - It is written to the FIFO at edge N+1.
  - m_axis_tvalid is high in the cycle after edge N+1 when the FIFO was empty.
- Sustained throughput: 1 pixel/cycle in and 1 pixel/cycle out.
- Flag and counter timing:
  - frame_error and overflow assert the cycle after the offending sample edge.
  - frames_done updates the cycle after the last pixel is sampled.
- Reset mid-frame: all state clears immediately and asynchronously, and buffered pixels are discarded.
  - After reset, output resumes only from the next s_frame_start.

## Test plan
- **Clean frames:** width 4, height 3, two clean frames, tready = 1 → 24 outputs.
  - tuser on outputs 0 and 12; tlast every 4th output.
  - frames_done = 2; no flags set.
- **Colour map:** s_data 0, 1, 100, 254, 255.
  - Expected tdata: 0x000000, 0x010204, 0x64C890, 0xFEFCF8, 0x000000.
- **Backpressure:** FIFO_DEPTH 4, width 8, tready = 0 for a full line.
  - The 5th and later pixels set overflow; only 4 entries emerge after tready rises.
  - The FSM resyncs on the next frame start.
- **Framing errors:**
  - Early line end: s_line_end at x = 2 with width 4 → frame_error = 1, the pixel is dropped, and nothing is accepted until the next frame start.
  - Frame start at (1,0) → frame_error = 1, and that pixel emerges with tuser = 1.
- **Stall hold and clear:** tready toggling 1/0 each cycle → tdata/tuser/tlast hold while stalled and no data is lost.
  - clear_errors asserted in the same cycle as an overflow → overflow stays 1.
- **Reset mid-frame:** reset asserted mid-frame with the FIFO non-empty → m_axis_tvalid = 0 immediately.
  - Mid-frame pixels after release are dropped until s_frame_start.

Source files
------------

// File: rtl/fractal_stream_receiver_if.sv
// AXI4-Stream video bus carrying {R,G,B} pixels plus start-of-frame and end-of-line markers.
interface fractal_stream_receiver_if;
  logic [23:0] tdata;
  logic        tuser;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/fractal_stream_receiver.sv
// Fractal pixel-stream consumer: framing check, iteration-to-RGB colour map, FWFT FIFO,
// re-emitted as an AXI4-Stream video master.
module fractal_stream_receiver #(
  parameter int unsigned FIFO_DEPTH = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [15:0]                      width_in,
  input  logic [15:0]                      height_in,
  input  logic [7:0]                       s_data,
  input  logic                             s_frame_start,
  input  logic                             s_line_end,
  input  logic                             s_valid,
  fractal_stream_receiver_if.master        m_axis,
  output logic                             overflow,
  output logic                             frame_error,
  input  logic                             clear_errors,
  output logic [31:0]                      frames_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [23:0] rgb;
  } entry_t;

  typedef enum logic {SYNC = 1'b0, ACTIVE = 1'b1} state_t;

  function automatic logic [23:0] colour_map(input logic [7:0] it);
    if (it == 8'd255) return 24'h000000;
    return {it, it[6:0], 1'b0, it[5:0], 2'b00};
  endfunction

  state_t          state, eff_state_c, state_n_c;
  logic [15:0]     x, y, w, h;
  logic [15:0]     px_c, py_c, pw_c, ph_c, nx_c, ny_c;
  logic            accept_c, fs_c, ferr_c, last_x_c, last_y_c, frame_done_c;

  entry_t          s1_entry;
  logic            s1_valid;

  entry_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_next_c;
  logic [CW-1:0]   count, count_next_c;
  logic            out_valid;
  entry_t          out_entry;
  logic            pop_c, push_c, full_c, ovf_c;

  // FIFO write/read decisions; full is judged at the write edge with the same-cycle pop.
  always_comb begin
    pop_c        = out_valid && m_axis.tready;
    full_c       = (count == CW'(FIFO_DEPTH));
    push_c       = s1_valid && (!full_c || pop_c);
    ovf_c        = s1_valid && full_c && !pop_c;
    rd_next_c    = rd_ptr + AW'(pop_c);
    count_next_c = count + CW'(push_c) - CW'(pop_c);
  end

  // Pixel acceptance and position tracking; an overflow forces this edge's pixel to be seen from SYNC.
  always_comb begin
    eff_state_c = ovf_c ? SYNC : state;
    state_n_c   = eff_state_c;
    accept_c    = 1'b0;
    fs_c        = 1'b0;
    ferr_c      = 1'b0;
    px_c        = x;
    py_c        = y;
    pw_c        = w;
    ph_c        = h;
    if (s_valid) begin
      if (s_frame_start) begin
        ferr_c    = (eff_state_c == ACTIVE) && ((x != 16'd0) || (y != 16'd0));
        accept_c  = 1'b1;
        fs_c      = 1'b1;
        px_c      = 16'd0;
        py_c      = 16'd0;
        pw_c      = width_in;
        ph_c      = height_in;
        state_n_c = ACTIVE;
      end else if (eff_state_c == ACTIVE) begin
        if (s_line_end != (x == w - 16'd1)) begin
          ferr_c    = 1'b1;
          state_n_c = SYNC;
        end else begin
          accept_c = 1'b1;
        end
      end
    end
    last_x_c     = (px_c == pw_c - 16'd1);
    last_y_c     = (py_c == ph_c - 16'd1);
    nx_c         = last_x_c ? 16'd0 : px_c + 16'd1;
    ny_c         = last_x_c ? (last_y_c ? 16'd0 : py_c + 16'd1) : py_c;
    frame_done_c = accept_c && last_x_c && last_y_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SYNC;
      x           <= 16'd0;
      y           <= 16'd0;
      w           <= 16'd0;
      h           <= 16'd0;
      s1_valid    <= 1'b0;
      s1_entry    <= '0;
      frames_done <= 32'd0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_entry   <= '0;
    end else begin
      state    <= state_n_c;
      s1_valid <= accept_c;
      if (accept_c) begin
        x        <= nx_c;
        y        <= ny_c;
        w        <= pw_c;
        h        <= ph_c;
        s1_entry <= '{tuser: fs_c, tlast: s_line_end, rgb: colour_map(s_data)};
      end
      if (frame_done_c) frames_done <= frames_done + 32'd1;

      // Error flags: a same-cycle set beats clear_errors.
      if (ferr_c)            frame_error <= 1'b1;
      else if (clear_errors) frame_error <= 1'b0;
      if (ovf_c)             overflow    <= 1'b1;
      else if (clear_errors) overflow    <= 1'b0;

      wr_ptr    <= wr_ptr + AW'(push_c);
      rd_ptr    <= rd_next_c;
      count     <= count_next_c;
      out_valid <= (count_next_c != '0);
      // Registered head; bypass when the entry being written becomes the head.
      if (count_next_c != '0)
        out_entry <= (push_c && (wr_ptr == rd_next_c)) ? s1_entry : mem[rd_next_c];
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= s1_entry;
  end

  assign m_axis.tdata  = out_entry.rgb;
  assign m_axis.tuser  = out_entry.tuser;
  assign m_axis.tlast  = out_entry.tlast;
  assign m_axis.tvalid = out_valid;

endmodule

// File: tb/tb_fractal_stream_receiver.sv
// Directed self-checking bench for fractal_stream_receiver (FIFO depth 4).
module tb_fractal_stream_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] width_in, height_in;
  logic [7:0]  s_data;
  logic        s_frame_start, s_line_end, s_valid;
  logic        overflow, frame_error, clear_errors;
  logic [31:0] frames_done;

  int errors = 0;
  int checks = 0;

  logic [25:0] got_q[$];

  fractal_stream_receiver_if m_if();

  fractal_stream_receiver #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .width_in(width_in), .height_in(height_in),
    .s_data(s_data), .s_frame_start(s_frame_start), .s_line_end(s_line_end),
    .s_valid(s_valid), .m_axis(m_if), .overflow(overflow), .frame_error(frame_error),
    .clear_errors(clear_errors), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  // Record every accepted output beat as {tuser, tlast, tdata}.
  always @(negedge clk) begin
    if (!reset && m_if.tvalid && m_if.tready)
      got_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
  end

  function automatic logic [23:0] exp_rgb(input int d);
    if (d == 255) return 24'h000000;
    return {8'(d), 8'(d * 2), 8'(d * 4)};
  endfunction

  task automatic pix(input int d, input logic fs, input logic le);
    s_data = 8'(d); s_frame_start = fs; s_line_end = le; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_frame_start = 1'b0; s_line_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_geom(input int wd, input int ht);
    width_in = 16'(wd); height_in = 16'(ht);
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1; idle(1); clear_errors = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== 24'h0 || m_if.tuser !== 1'b0 || m_if.tlast !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: tvalid=%b tdata=%h tuser=%b tlast=%b, want 0", m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast);
    end
    checks++;
    if (overflow !== 1'b0 || frame_error !== 1'b0 || frames_done !== 32'd0) begin
      errors++; $display("FAIL reset_flags: ovf=%b ferr=%b frames=%0d, want 0", overflow, frame_error, frames_done);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_clean_frames();
    logic [25:0] exp;
    got_q.delete();
    set_geom(4, 3);
    for (int i = 0; i < 24; i++) pix(i, (i % 12) == 0, (i % 4) == 3);
    idle(6);
    checks++;
    if (got_q.size() != 24) begin
      errors++; $display("FAIL clean_count: got %0d outputs, want 24", got_q.size());
    end
    for (int i = 0; i < 24 && i < got_q.size(); i++) begin
      exp = {(i % 12) == 0, (i % 4) == 3, exp_rgb(i)};
      checks++;
      if (got_q[i] !== exp) begin
        errors++; $display("FAIL clean_beat%0d: got %h, want %h", i, got_q[i], exp);
      end
    end
    checks++;
    if (frames_done !== 32'd2 || overflow !== 1'b0 || frame_error !== 1'b0) begin
      errors++; $display("FAIL clean_status: frames=%0d ovf=%b ferr=%b, want 2/0/0", frames_done, overflow, frame_error);
    end
  endtask

  task automatic test_colour_map();
    int          d[5] = '{0, 1, 100, 254, 255};
    logic [23:0] exp[5] = '{24'h000000, 24'h010204, 24'h64C890, 24'hFEFCF8, 24'h000000};
    got_q.delete();
    set_geom(5, 1);
    for (int i = 0; i < 5; i++) pix(d[i], i == 0, i == 4);
    idle(5);
    checks++;
    if (got_q.size() != 5) begin
      errors++; $display("FAIL colour_count: got %0d outputs, want 5", got_q.size());
    end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i][23:0] !== exp[i]) begin
        errors++; $display("FAIL colour_%0d: got %h, want %h", d[i], got_q[i][23:0], exp[i]);
      end
    end
    checks++;
    if (frames_done !== 32'd3) begin
      errors++; $display("FAIL colour_frames: got %0d, want 3", frames_done);
    end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    m_if.tready = 1'b0;
    set_geom(8, 1);
    for (int i = 0; i < 5; i++) pix(10 + i, i == 0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL bp_no_early_ovf: overflow=%b, want 0", overflow);
    end
    clear_errors = 1'b1;
    pix(15, 1'b0, 1'b0);
    clear_errors = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL bp_ovf_set_beats_clear: overflow=%b, want 1", overflow);
    end
    pix(16, 1'b0, 1'b0);
    pix(17, 1'b0, 1'b1);
    idle(2);
    checks++;
    if (frame_error !== 1'b0 || overflow !== 1'b1 || m_if.tvalid !== 1'b1) begin
      errors++; $display("FAIL bp_status: ferr=%b ovf=%b tvalid=%b, want 0/1/1", frame_error, overflow, m_if.tvalid);
    end
    m_if.tready = 1'b1;
    idle(8);
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL bp_count: got %0d outputs, want 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {i == 0, 1'b0, exp_rgb(10 + i)}) begin
        errors++; $display("FAIL bp_beat%0d: got %h, want %h", i, got_q[i], {i == 0, 1'b0, exp_rgb(10 + i)});
      end
    end
    pulse_clear();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL bp_clear: overflow=%b, want 0", overflow);
    end
    got_q.delete();
    pix(30, 1'b0, 1'b0);
    set_geom(2, 1);
    pix(31, 1'b1, 1'b0);
    pix(32, 1'b0, 1'b1);
    idle(5);
    checks++;
    if (got_q.size() != 2 || frames_done !== 32'd4) begin
      errors++; $display("FAIL bp_resync: got %0d outputs frames=%0d, want 2/4", got_q.size(), frames_done);
    end else begin
      checks++;
      if (got_q[0] !== {2'b10, exp_rgb(31)} || got_q[1] !== {2'b01, exp_rgb(32)}) begin
        errors++; $display("FAIL bp_resync_data: got %h %h", got_q[0], got_q[1]);
      end
    end
  endtask

  task automatic test_framing_errors();
    got_q.delete();
    set_geom(4, 2);
    pix(40, 1'b1, 1'b0);
    pix(41, 1'b0, 1'b0);
    checks++;
    if (frame_error !== 1'b0) begin
      errors++; $display("FAIL early_le_before: frame_error=%b, want 0", frame_error);
    end
    pix(42, 1'b0, 1'b1);
    checks++;
    if (frame_error !== 1'b1) begin
      errors++; $display("FAIL early_le_flag: frame_error=%b, want 1", frame_error);
    end
    pix(43, 1'b0, 1'b1);
    pix(44, 1'b0, 1'b0);
    idle(5);
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL early_le_count: got %0d outputs, want 2", got_q.size());
    end
    pulse_clear();
    checks++;
    if (frame_error !== 1'b0) begin
      errors++; $display("FAIL ferr_clear: frame_error=%b, want 0", frame_error);
    end
    got_q.delete();
    set_geom(4, 1);
    pix(50, 1'b1, 1'b0);
    pix(51, 1'b1, 1'b0);
    checks++;
    if (frame_error !== 1'b1) begin
      errors++; $display("FAIL midframe_fs_flag: frame_error=%b, want 1", frame_error);
    end
    pix(52, 1'b0, 1'b0);
    pix(53, 1'b0, 1'b0);
    pix(54, 1'b0, 1'b1);
    idle(5);
    checks++;
    if (got_q.size() != 5 || frames_done !== 32'd5) begin
      errors++; $display("FAIL midframe_fs_count: got %0d outputs frames=%0d, want 5/5", got_q.size(), frames_done);
    end else begin
      checks++;
      if (got_q[1] !== {2'b10, exp_rgb(51)} || got_q[4] !== {2'b01, exp_rgb(54)}) begin
        errors++; $display("FAIL midframe_fs_tuser: got %h %h", got_q[1], got_q[4]);
      end
    end
    pulse_clear();
  endtask

  task automatic test_stall_hold();
    logic        prev_stall = 1'b0;
    logic [25:0] prev_val = '0;
    logic [25:0] cur;
    got_q.delete();
    set_geom(4, 2);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          pix(60 + i, i == 0, (i % 4) == 3);
          idle(2);
        end
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge clk); #1;
          m_if.tready = ~m_if.tready;
          @(negedge clk);
          cur = {m_if.tuser, m_if.tlast, m_if.tdata};
          if (prev_stall) begin
            checks++;
            if (cur !== prev_val) begin
              errors++; $display("FAIL stall_hold: got %h, want held %h", cur, prev_val);
            end
          end
          prev_stall = m_if.tvalid && !m_if.tready;
          prev_val   = cur;
        end
      end
    join
    m_if.tready = 1'b1;
    idle(6);
    checks++;
    if (got_q.size() != 8 || overflow !== 1'b0) begin
      errors++; $display("FAIL stall_count: got %0d outputs ovf=%b, want 8/0", got_q.size(), overflow);
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {i == 0, (i % 4) == 3, exp_rgb(60 + i)}) begin
        errors++; $display("FAIL stall_beat%0d: got %h, want %h", i, got_q[i], {i == 0, (i % 4) == 3, exp_rgb(60 + i)});
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    m_if.tready = 1'b0;
    set_geom(4, 3);
    pix(70, 1'b1, 1'b0);
    pix(71, 1'b0, 1'b0);
    pix(72, 1'b0, 1'b0);
    idle(1);
    checks++;
    if (m_if.tvalid !== 1'b1) begin
      errors++; $display("FAIL rst_pre_tvalid: tvalid=%b, want 1", m_if.tvalid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== 24'h0 || frames_done !== 32'd0) begin
      errors++; $display("FAIL rst_async: tvalid=%b tdata=%h frames=%0d, want 0", m_if.tvalid, m_if.tdata, frames_done);
    end
    idle(1);
    reset = 1'b0;
    got_q.delete();
    m_if.tready = 1'b1;
    pix(73, 1'b0, 1'b1);
    pix(74, 1'b0, 1'b0);
    pix(75, 1'b0, 1'b0);
    idle(5);
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL rst_drop: got %0d outputs, want 0", got_q.size());
    end
    set_geom(1, 1);
    pix(200, 1'b1, 1'b1);
    idle(5);
    checks++;
    if (got_q.size() != 1 || frames_done !== 32'd1) begin
      errors++; $display("FAIL rst_resume: got %0d outputs frames=%0d, want 1/1", got_q.size(), frames_done);
    end else begin
      checks++;
      if (got_q[0] !== {2'b11, exp_rgb(200)}) begin
        errors++; $display("FAIL rst_resume_data: got %h, want %h", got_q[0], {2'b11, exp_rgb(200)});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    width_in = 16'd4; height_in = 16'd3;
    s_data = 8'd0; s_frame_start = 1'b0; s_line_end = 1'b0; s_valid = 1'b0;
    clear_errors = 1'b0;
    m_if.tready = 1'b1;
    test_reset();
    test_clean_frames();
    test_colour_map();
    test_backpressure();
    test_framing_errors();
    test_stall_hold();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
